// File: rtl/labft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : labft_pkg
// Description : Shared types and helpers for the LABFT checksum error monitor.
//               - monitor_state_t : 2-bit state encoding (IDLE/MONITOR/ERROR)
//               - lowest_set_index: index of the least-significant set bit
// Revision    : 1.0 - initial release
// ============================================================================
package labft_pkg;

    // Upper bound on the channel count that the index helper can scan.
    localparam int LABFT_MAX_CHANNELS = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        ERROR   = 2'd2
    } monitor_state_t;

    // Returns the index of the lowest set bit, or 0 when no bit is set.
    // Scanning from the top down lets the lowest index overwrite the others.
    function automatic int unsigned lowest_set_index(
        input logic [LABFT_MAX_CHANNELS-1:0] vec
    );
        int unsigned idx;
        idx = 0;
        for (int i = LABFT_MAX_CHANNELS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage : labft_pkg
`default_nettype wire

// File: rtl/labft_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : labft_delay_line
// Description : Enabled shift register with asynchronous active-high reset.
//               Every enabled clock moves din into stage 0 and each stage
//               one position further; dout is the last stage.
// Ports       : clk, rst       - clock, async active-high reset
//               en             - shift enable
//               din  [WIDTH]   - value entering the line
//               dout [WIDTH]   - oldest value (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module labft_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule : labft_delay_line
`default_nettype wire

// File: rtl/labft_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : labft_error_monitor
// Description : Compares delayed dot-product checksums against accumulator
//               checksums on numChannels channels, latches a sticky error
//               vector, records the first failing channel, counts failing
//               compares (saturating) and pulses irq on entry to ERROR.
// Ports       : clk, rst        - clock, async active-high reset
//               interrupt       - host acknowledge, returns to IDLE
//               count_clr       - synchronous clear of error_count
//               valid_dot       - shifts the dot alignment lines
//               valid_acc       - launches a compare
//               dot_bus/acc_bus - packed checksums, channel i at
//                                 [i*dataWidth +: dataWidth]
//               error           - sticky per-channel error flags
//               first_chan      - lowest failing channel of first failure
//               error_count     - saturating failing-compare count
//               irq             - one-cycle pulse on entry to ERROR
// Revision    : 1.0 - initial release
// ============================================================================
module labft_error_monitor
    import labft_pkg::*;
#(
    parameter int arraySize   = 4,
    parameter int inputBits   = 8,
    parameter int numChannels = 4,
    parameter int dotDelay    = 2,
    parameter int countWidth  = 8,
    parameter int dataWidth   = 2 * inputBits + 3 * arraySize,
    parameter int chanWidth   = (numChannels > 1) ? $clog2(numChannels) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             interrupt,
    input  logic                             count_clr,
    input  logic                             valid_dot,
    input  logic                             valid_acc,
    input  logic [numChannels*dataWidth-1:0] dot_bus,
    input  logic [numChannels*dataWidth-1:0] acc_bus,
    output logic [numChannels-1:0]           error,
    output logic [chanWidth-1:0]             first_chan,
    output logic [countWidth-1:0]            error_count,
    output logic                             irq
);

    // ------------------------------------------------------------------
    // Alignment lines and raw per-channel compare
    // ------------------------------------------------------------------
    logic [dataWidth-1:0]   last_stage [numChannels];
    logic [numChannels-1:0] mismatch_raw;

    generate
        for (genvar g = 0; g < numChannels; g++) begin : g_chan
            labft_delay_line #(
                .WIDTH (dataWidth),
                .DEPTH (dotDelay)
            ) u_delay_line (
                .clk  (clk),
                .rst  (rst),
                .en   (valid_dot),
                .din  (dot_bus[g*dataWidth +: dataWidth]),
                .dout (last_stage[g])
            );

            // Uses the pre-shift last stage even when valid_dot is high.
            assign mismatch_raw[g] = (last_stage[g] != acc_bus[g*dataWidth +: dataWidth]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Compare stage
    // ------------------------------------------------------------------
    logic [numChannels-1:0] mismatch_q, mismatch_d;
    logic                   cmp_valid_q, cmp_valid_d;

    always_comb begin
        mismatch_d  = valid_acc ? mismatch_raw : mismatch_q;
        cmp_valid_d = valid_acc;
    end

    logic cmp_fail;
    assign cmp_fail = cmp_valid_q && (|mismatch_q);

    logic [LABFT_MAX_CHANNELS-1:0] mismatch_ext;
    assign mismatch_ext = LABFT_MAX_CHANNELS'(mismatch_q);

    // ------------------------------------------------------------------
    // Control FSM and error state
    // ------------------------------------------------------------------
    monitor_state_t         state_q, state_d;
    logic [numChannels-1:0] error_q, error_d;
    logic [chanWidth-1:0]   first_chan_q, first_chan_d;
    logic                   irq_q, irq_d;

    always_comb begin
        state_d      = state_q;
        error_d      = error_q;
        first_chan_d = first_chan_q;
        irq_d        = 1'b0;

        case (state_q)
            IDLE: begin
                // Compares landing here are ignored; only a new valid_acc
                // arms the monitor.
                error_d      = '0;
                first_chan_d = '0;
                if (valid_acc) begin
                    state_d = MONITOR;
                end
            end
            MONITOR: begin
                if (cmp_fail) begin
                    error_d      = mismatch_q;
                    first_chan_d = chanWidth'(lowest_set_index(mismatch_ext));
                    irq_d        = 1'b1;
                    state_d      = ERROR;
                end
            end
            ERROR: begin
                if (cmp_fail) begin
                    error_d = error_q | mismatch_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acknowledge overrides everything, including a coincident failure.
        if (interrupt) begin
            state_d      = IDLE;
            error_d      = '0;
            first_chan_d = '0;
            irq_d        = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating mismatch counter
    // ------------------------------------------------------------------
    logic [countWidth-1:0] count_q, count_d;
    logic                  count_inc;

    // Counts even when interrupt coincides, since it keys off the current state.
    assign count_inc = cmp_fail && ((state_q == MONITOR) || (state_q == ERROR));

    always_comb begin
        count_d = count_q;
        if (count_clr) begin
            count_d = '0;
        end else if (count_inc && (count_q != {countWidth{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q   <= '0;
            cmp_valid_q  <= 1'b0;
            state_q      <= IDLE;
            error_q      <= '0;
            first_chan_q <= '0;
            irq_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            mismatch_q   <= mismatch_d;
            cmp_valid_q  <= cmp_valid_d;
            state_q      <= state_d;
            error_q      <= error_d;
            first_chan_q <= first_chan_d;
            irq_q        <= irq_d;
            count_q      <= count_d;
        end
    end

    assign error       = error_q;
    assign first_chan  = first_chan_q;
    assign error_count = count_q;
    assign irq         = irq_q;

endmodule : labft_error_monitor
`default_nettype wire

// File: tb/tb_labft_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_labft_error_monitor
// Description : Directed self-checking bench for labft_error_monitor.
//               Two instances share stimulus: the main one (countWidth=8)
//               and a narrow-counter one (countWidth=2) for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_labft_error_monitor;
    import labft_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 28;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              interrupt = 1'b0;
    logic              count_clr = 1'b0;
    logic              valid_dot = 1'b0;
    logic              valid_acc = 1'b0;
    logic [NCH*DW-1:0] dot_bus = '0;
    logic [NCH*DW-1:0] acc_bus = '0;

    logic [NCH-1:0]    error;
    logic [1:0]        first_chan;
    logic [7:0]        error_count;
    logic              irq;

    logic [NCH-1:0]    error_s;
    logic [1:0]        first_chan_s;
    logic [1:0]        error_count_s;
    logic              irq_s;

    always #5 clk = ~clk;

    labft_error_monitor #(
        .arraySize(4), .inputBits(8), .numChannels(NCH), .dotDelay(2), .countWidth(8)
    ) dut (
        .clk(clk), .rst(rst), .interrupt(interrupt), .count_clr(count_clr),
        .valid_dot(valid_dot), .valid_acc(valid_acc),
        .dot_bus(dot_bus), .acc_bus(acc_bus),
        .error(error), .first_chan(first_chan), .error_count(error_count), .irq(irq)
    );

    labft_error_monitor #(
        .arraySize(4), .inputBits(8), .numChannels(NCH), .dotDelay(2), .countWidth(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .interrupt(interrupt), .count_clr(count_clr),
        .valid_dot(valid_dot), .valid_acc(valid_acc),
        .dot_bus(dot_bus), .acc_bus(acc_bus),
        .error(error_s), .first_chan(first_chan_s), .error_count(error_count_s), .irq(irq_s)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int irq_seen = 0;
    int beat     = 0;

    // Bench model of the two-stage alignment line (m1 is the last stage).
    logic [DW-1:0] m0 [NCH];
    logic [DW-1:0] m1 [NCH];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_dot = 1'b0; valid_acc = 1'b0; interrupt = 1'b0; count_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m0[c] = '0;
            m1[c] = '0;
        end
        irq_seen = 0;
    endtask

    // One clock: inputs applied at a negedge, outputs observed at the next.
    task automatic cyc(input logic vd, input logic va, input logic [NCH-1:0] fmask,
                       input logic intr, input logic cclr);
        logic [NCH*DW-1:0] db;
        logic [NCH*DW-1:0] ab;
        for (int c = 0; c < NCH; c++) begin
            db[c*DW +: DW] = DW'(beat * 17 + c * 3 + 1);
            ab[c*DW +: DW] = m1[c] ^ (fmask[c] ? DW'(1) : DW'(0));
        end
        dot_bus = db; acc_bus = ab;
        valid_dot = vd; valid_acc = va; interrupt = intr; count_clr = cclr;
        @(negedge clk);
        if (vd) begin
            for (int c = 0; c < NCH; c++) begin
                m1[c] = m0[c];
                m0[c] = db[c*DW +: DW];
            end
        end
        beat++;
        if (irq) irq_seen++;
        valid_dot = 1'b0; valid_acc = 1'b0; interrupt = 1'b0; count_clr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (error !== 4'b0000) begin n_fail++; $display("FAIL reset_error actual=%b required=%b", error, 4'b0000); end
        n_checks++; if (first_chan !== 2'd0) begin n_fail++; $display("FAIL reset_first_chan actual=%0d required=0", first_chan); end
        n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL reset_count actual=%0d required=0", error_count); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq actual=%b required=0", irq); end
    endtask

    task automatic test_clean_run();
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_checks++; if (error !== 4'b0000) begin n_fail++; $display("FAIL clean_error actual=%b required=0000", error); end
        n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL clean_count actual=%0d required=0", error_count); end
        n_checks++; if (irq_seen !== 0) begin n_fail++; $display("FAIL clean_irq_pulses actual=%0d required=0", irq_seen); end
        n_checks++; if (dut.state_q !== MONITOR) begin n_fail++; $display("FAIL clean_state actual=%0d required=%0d", dut.state_q, MONITOR); end
    endtask

    task automatic test_single_fault();
        do_reset();
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 4'b0100, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_early actual=%b required=0", irq); end
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq actual=%b required=1", irq); end
        n_checks++; if (error !== 4'b0100) begin n_fail++; $display("FAIL single_error actual=%b required=0100", error); end
        n_checks++; if (first_chan !== 2'd2) begin n_fail++; $display("FAIL single_first_chan actual=%0d required=2", first_chan); end
        n_checks++; if (error_count !== 8'd1) begin n_fail++; $display("FAIL single_count actual=%0d required=1", error_count); end
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_width actual=%b required=0", irq); end
        n_checks++; if (error !== 4'b0100) begin n_fail++; $display("FAIL single_error_sticky actual=%b required=0100", error); end
    endtask

    task automatic test_accumulation();
        do_reset();
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
        n_checks++; if (error !== 4'b0010) begin n_fail++; $display("FAIL accum_error_first actual=%b required=0010", error); end
        cyc(1'b1, 1'b1, 4'b1000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_checks++; if (error !== 4'b1010) begin n_fail++; $display("FAIL accum_error actual=%b required=1010", error); end
        n_checks++; if (first_chan !== 2'd1) begin n_fail++; $display("FAIL accum_first_chan actual=%0d required=1", first_chan); end
        n_checks++; if (irq_seen !== 1) begin n_fail++; $display("FAIL accum_irq_pulses actual=%0d required=1", irq_seen); end
        n_checks++; if (error_count !== 8'd2) begin n_fail++; $display("FAIL accum_count actual=%0d required=2", error_count); end
    endtask

    task automatic test_ack();
        do_reset();
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_checks++; if (dut.state_q !== ERROR) begin n_fail++; $display("FAIL ack_pre_state actual=%0d required=%0d", dut.state_q, ERROR); end
        cyc(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        n_checks++; if (error !== 4'b0000) begin n_fail++; $display("FAIL ack_error actual=%b required=0000", error); end
        n_checks++; if (first_chan !== 2'd0) begin n_fail++; $display("FAIL ack_first_chan actual=%0d required=0", first_chan); end
        n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL ack_state actual=%0d required=%0d", dut.state_q, IDLE); end
        n_checks++; if (error_count !== 8'd2) begin n_fail++; $display("FAIL ack_count actual=%0d required=2", error_count); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ack_irq actual=%b required=0", irq); end
        n_checks++; if (irq_seen !== 1) begin n_fail++; $display("FAIL ack_irq_pulses actual=%0d required=1", irq_seen); end
    endtask

    task automatic test_back_to_back_saturation();
        do_reset();
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_checks++; if (error_count_s !== 2'd3) begin n_fail++; $display("FAIL sat_count actual=%0d required=3", error_count_s); end
        n_checks++; if (error_count !== 8'd5) begin n_fail++; $display("FAIL b2b_count actual=%0d required=5", error_count); end
        cyc(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        n_checks++; if (error_count_s !== 2'd0) begin n_fail++; $display("FAIL sat_clear actual=%0d required=0", error_count_s); end
        n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL clr_count actual=%0d required=0", error_count); end
        n_checks++; if (error !== 4'b0001) begin n_fail++; $display("FAIL clr_keeps_error actual=%b required=0001", error); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        n_checks++; if (error !== 4'b0010) begin n_fail++; $display("FAIL areset_pre_error actual=%b required=0010", error); end
        // Another failing compare is in flight; reset lands between edges.
        valid_acc = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (error !== 4'b0000) begin n_fail++; $display("FAIL areset_error actual=%b required=0000", error); end
        n_checks++; if (first_chan !== 2'd0) begin n_fail++; $display("FAIL areset_first_chan actual=%0d required=0", first_chan); end
        n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL areset_count actual=%0d required=0", error_count); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL areset_irq actual=%b required=0", irq); end
        valid_acc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m0[c] = '0;
            m1[c] = '0;
        end
        cyc(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        n_checks++; if (dut.state_q !== MONITOR) begin n_fail++; $display("FAIL areset_rearm_state actual=%0d required=%0d", dut.state_q, MONITOR); end
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_checks++; if (error !== 4'b0000) begin n_fail++; $display("FAIL areset_post_error actual=%b required=0000", error); end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_single_fault();
        test_accumulation();
        test_ack();
        test_back_to_back_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_labft_error_monitor
`default_nettype wire
